// File: rtl/serial_add_controller_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_controller_pkg
//
// Shared definitions for the bit-serial adder sequencer:
//   - controller state encoding (IDLE / RUN / DONE) and the matching enum type
//   - legal range of the operand width parameter
//   - a helper used by the controller to reject out-of-range widths at
//     elaboration time
// -----------------------------------------------------------------------------
package serial_add_controller_pkg;

    // Controller state encoding.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

    // Operand width limits.
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_is_legal(input int width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_add_controller_full_adder.sv
// -----------------------------------------------------------------------------
// Full_Adder
//
// One-bit combinational full adder cell shared by the serial add sequencer.
//
// Ports:
//   a         in  1  first addend bit
//   b         in  1  second addend bit
//   carry_in  in  1  incoming carry
//   sum       out 1  a ^ b ^ carry_in
//   carry_out out 1  majority(a, b, carry_in)
// -----------------------------------------------------------------------------
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_add_controller.sv
// -----------------------------------------------------------------------------
// serial_add_controller
//
// Bit-serial adder sequencer. On an accepted start it captures two WIDTH-bit
// operands and a carry-in, then feeds one bit pair per clock (LSB first) into a
// single Full_Adder, keeping the running carry in a flop. Sum bits enter the
// result register at the MSB end and move right, so after WIDTH shifts bit i
// sits at position i. The final carry and a one-cycle done pulse follow.
//
// Ports:
//   clock         in   1      rising-edge clock
//   reset         in   1      synchronous, active-high; clears all state
//   start         in   1      request; accepted only while busy=0
//   operand_one   in   WIDTH  first addend, captured on accepted start
//   operand_two   in   WIDTH  second addend, captured on accepted start
//   carry_in      in   1      initial carry, captured on accepted start
//   busy          out  1      high while running and during the done cycle
//   done          out  1      one-cycle pulse, result valid
//   result_sum    out  WIDTH  sum, held until the next accepted start
//   result_carry  out  1      carry-out, held until the next accepted start
// -----------------------------------------------------------------------------
module serial_add_controller
    import serial_add_controller_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_one,
    input  logic [WIDTH-1:0] operand_two,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_sum,
    output logic             result_carry
);

    // A 1-bit counter is kept even for WIDTH=1 so the compare below is uniform.
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    if (!width_is_legal(WIDTH)) begin : g_bad_width
        $error("serial_add_controller: WIDTH out of range");
    end

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             carry_q,     carry_d;
    logic             res_carry_q, res_carry_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_shifted;

    // -------------------------------------------------------------------------
    // Shared one-bit adder: always looks at the current LSBs and carry flop.
    // -------------------------------------------------------------------------
    Full_Adder u_full_adder (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_carry)
    );

    // -------------------------------------------------------------------------
    // Result register right shift with the new sum bit entering at the MSB.
    // Written bit by bit so WIDTH=1 needs no special case (empty loop).
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
        assign sum_shifted[gi] = sum_q[gi+1];
    end
    assign sum_shifted[WIDTH-1] = fa_sum;

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        res_carry_d = res_carry_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d         = operand_one;
                    b_d         = operand_two;
                    carry_d     = carry_in;
                    cnt_d       = '0;
                    sum_d       = '0;
                    res_carry_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_RUN;
                end
            end

            ST_RUN: begin
                sum_d   = sum_shifted;
                carry_d = fa_carry;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    res_carry_d = fa_carry;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                // start is deliberately not examined here: no back-to-back
                // acceptance, the next request is seen once back in IDLE.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers. Reset discards any partial result.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            res_carry_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            res_carry_q <= res_carry_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_sum   = sum_q;
    assign result_carry = res_carry_q;

endmodule
